// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: after the start detector's edge, shifts in an MSB-first
// payload plus optional even parity and offers it on a valid/ready port.
module serial_frame_receiver #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_data,
    input  logic              i_start_in,
    input  logic              i_out_ready,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_parity_err,
    output logic              o_det_clear,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_frame_cnt
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start_q;
    logic [DATA_W-1:0]   r_sr;
    logic [BC_W-1:0]     r_bit_cnt;
    logic                r_parity_err;
    logic                r_det_clear;
    logic [CNT_W-1:0]    r_frame_cnt;

    logic                w_start_edge;
    logic                w_load;
    logic                w_shift;
    logic                w_par_sample;
    logic                w_accept;

    assign w_start_edge = i_start_in & ~r_start_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_par_sample = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Without parity the DONE transition takes one extra edge once the
                // counter is full, keeping valid at first-bit edge + DATA_W.
                if (r_bit_cnt != BC_FULL) begin
                    w_shift = 1'b1;
                    if ((PARITY_EN != 0) && (r_bit_cnt == BC_LAST))
                        w_state_nxt = S_PARITY;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_PARITY: begin
                w_par_sample = 1'b1;
                w_state_nxt  = S_DONE;
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b0;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_parity_err <= 1'b0;
            r_det_clear  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_q   <= i_start_in;
            r_det_clear <= w_accept;
            if (w_load) begin
                r_sr         <= {r_sr[DATA_W-2:0], i_data};
                r_bit_cnt    <= BC_W'(1);
                r_parity_err <= 1'b0;
            end else if (w_shift) begin
                r_sr      <= {r_sr[DATA_W-2:0], i_data};
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
            if (w_par_sample)
                r_parity_err <= (PARITY_EN != 0) & (^r_sr ^ i_data);
            if (w_accept)
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    assign o_out_valid  = (r_state == S_DONE);
    assign o_out_data   = r_sr;
    assign o_parity_err = r_parity_err;
    assign o_det_clear  = r_det_clear;
    assign o_busy       = (r_state == S_SHIFT) || (r_state == S_PARITY);
    assign o_frame_cnt  = r_frame_cnt;

endmodule
